// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocation from dispatch, out-of-order
// completion from writeback, in-order retirement one entry per cycle.

package core_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        exc;
    } ROB_Entry;

endpackage

module reorder_buffer
    import core_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             disp_valid,
    input  ROB_Entry         disp_entry,
    output logic             disp_ready,
    output logic [IDX_W-1:0] disp_idx,
    input  logic             wb_valid,
    input  logic [IDX_W-1:0] wb_idx,
    output logic             commit_valid,
    output ROB_Entry         commit_entry,
    output logic [IDX_W-1:0] commit_idx,
    input  logic             commit_ready,
    input  logic             flush,
    output logic             empty,
    output logic             full,
    output logic [IDX_W:0]   count
);

    localparam logic [IDX_W:0] PTR_ONE = 1;

    ROB_Entry         payload [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] done;
    logic [IDX_W:0]   head;
    logic [IDX_W:0]   tail;

    logic [IDX_W-1:0] head_lo;
    logic [IDX_W-1:0] tail_lo;
    logic             alloc_fire;
    logic             commit_fire;

    assign head_lo = head[IDX_W-1:0];
    assign tail_lo = tail[IDX_W-1:0];

    // Occupancy and handshake status derived purely from registered state,
    // so a same-cycle commit never opens a slot for allocation while full.
    always_comb begin
        full         = (head[IDX_W] != tail[IDX_W]) && (head_lo == tail_lo);
        empty        = (head == tail);
        count        = tail - head;
        disp_ready   = !full;
        disp_idx     = tail_lo;
        commit_idx   = head_lo;
        commit_valid = valid[head_lo] && done[head_lo];
        commit_entry = payload[head_lo];
        alloc_fire   = disp_valid && disp_ready;
        commit_fire  = commit_valid && commit_ready;
    end

    // Slot and pointer state; flush outranks every same-edge update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            valid <= '0;
            done  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                payload[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            valid <= '0;
            done  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                payload[i] <= '0;
            end
        end else begin
            if (wb_valid && valid[wb_idx]) begin
                done[wb_idx] <= 1'b1;
            end
            if (alloc_fire) begin
                payload[tail_lo] <= disp_entry;
                valid[tail_lo]   <= 1'b1;
                done[tail_lo]    <= 1'b0;
                tail             <= tail + PTR_ONE;
            end
            if (commit_fire) begin
                valid[head_lo] <= 1'b0;
                done[head_lo]  <= 1'b0;
                head           <= head + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected retirements are queued
// at allocation and checked by an independent commit monitor.

module tb_reorder_buffer;
    import core_pkg::*;

    localparam int DEPTH = 16;
    localparam int IDX_W = 4;

    typedef struct {
        logic [IDX_W-1:0] idx;
        ROB_Entry         entry;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             disp_valid;
    ROB_Entry         disp_entry;
    logic             disp_ready;
    logic [IDX_W-1:0] disp_idx;
    logic             wb_valid;
    logic [IDX_W-1:0] wb_idx;
    logic             commit_valid;
    ROB_Entry         commit_entry;
    logic [IDX_W-1:0] commit_idx;
    logic             commit_ready;
    logic             flush;
    logic             empty;
    logic             full;
    logic [IDX_W:0]   count;

    int   n_checks;
    int   n_fail;
    int   tail_m;
    int   n_commits;
    exp_t exp_q[$];

    reorder_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .disp_valid   (disp_valid),
        .disp_entry   (disp_entry),
        .disp_ready   (disp_ready),
        .disp_idx     (disp_idx),
        .wb_valid     (wb_valid),
        .wb_idx       (wb_idx),
        .commit_valid (commit_valid),
        .commit_entry (commit_entry),
        .commit_idx   (commit_idx),
        .commit_ready (commit_ready),
        .flush        (flush),
        .empty        (empty),
        .full         (full),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ROB_Entry mk(input int n);
        ROB_Entry e;
        e.pc  = 32'h1000 + 32'(n * 4);
        e.rd  = 5'(n);
        e.exc = n[0];
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one entry for a single cycle; expect it to be accepted.
    task automatic alloc(input int n);
        exp_t x;
        disp_valid = 1'b1;
        disp_entry = mk(n);
        chk("disp_ready", disp_ready, 1'b1);
        chk("disp_idx", disp_idx, 64'(tail_m % DEPTH));
        x.idx   = IDX_W'(tail_m % DEPTH);
        x.entry = mk(n);
        exp_q.push_back(x);
        step();
        tail_m++;
        disp_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_q.delete();
        tail_m = 0;
    endtask

    task automatic wb(input int idx);
        wb_valid = 1'b1;
        wb_idx   = IDX_W'(idx);
        step();
        wb_valid = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, disp_ready, 1'b1);
        chk({tag, "_didx"}, disp_idx, 0);
        chk({tag, "_cvalid"}, commit_valid, 1'b0);
        chk({tag, "_cidx"}, commit_idx, 0);
        chk({tag, "_centry"}, commit_entry, 0);
        chk({tag, "_empty"}, empty, 1'b1);
        chk({tag, "_full"}, full, 1'b0);
        chk({tag, "_count"}, count, 0);
    endtask

    // Commit monitor: every retirement must match the oldest allocation.
    always @(negedge clk) begin
        if (rst_n && commit_valid && commit_ready && !flush) begin
            n_commits++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL commit_unexpected: got idx %0d expected none",
                         commit_idx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("commit_idx", commit_idx, e.idx);
                chk("commit_entry", commit_entry, e.entry);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        n_commits    = 0;
        tail_m       = 0;
        rst_n        = 1'b0;
        disp_valid   = 1'b0;
        disp_entry   = '0;
        wb_valid     = 1'b0;
        wb_idx       = '0;
        commit_ready = 1'b0;
        flush        = 1'b0;
        #2;
        chk_reset_outs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1: three back-to-back allocations, nothing committable
        for (int i = 0; i < 3; i++) begin
            disp_valid = 1'b1;
            disp_entry = mk(i);
            chk("t1_didx", disp_idx, 64'(i));
            chk("t1_cvalid", commit_valid, 1'b0);
            begin
                exp_t x;
                x.idx   = IDX_W'(i);
                x.entry = mk(i);
                exp_q.push_back(x);
            end
            step();
            tail_m++;
        end
        disp_valid = 1'b0;
        chk("t1_count", count, 3);
        chk("t1_cvalid_end", commit_valid, 1'b0);

        // 2: out-of-order completion, in-order retirement
        commit_ready = 1'b1;
        wb(1);
        chk("t2_cvalid_wb1", commit_valid, 1'b0);
        wb(0);
        chk("t2_cvalid_0", commit_valid, 1'b1);
        chk("t2_cidx_0", commit_idx, 0);
        step();
        chk("t2_cvalid_1", commit_valid, 1'b1);
        chk("t2_cidx_1", commit_idx, 1);
        step();
        chk("t2_count", count, 1);
        chk("t2_cvalid_2", commit_valid, 1'b0);
        wb(2);
        step();
        chk("t2_empty", empty, 1'b1);
        chk("t2_commits", n_commits, 3);
        commit_ready = 1'b0;

        // 3: fill to full, overflow attempt dropped
        do_flush();
        for (int i = 0; i < DEPTH; i++) alloc(10 + i);
        chk("t3_full", full, 1'b1);
        chk("t3_ready", disp_ready, 1'b0);
        chk("t3_count", count, 16);
        disp_valid = 1'b1;
        disp_entry = mk(99);
        step();
        chk("t3_drop_count", count, 16);

        // 4: full + head done: commit fires, held alloc waits a cycle
        wb_valid = 1'b1;
        wb_idx   = 4'd0;
        step();
        wb_valid = 1'b0;
        chk("t4_cvalid", commit_valid, 1'b1);
        chk("t4_ready_full", disp_ready, 1'b0);
        commit_ready = 1'b1;
        step();
        commit_ready = 1'b0;
        chk("t4_count", count, 15);
        chk("t4_full", full, 1'b0);
        chk("t4_ready", disp_ready, 1'b1);
        chk("t4_didx_wrap", disp_idx, 0);
        begin
            exp_t x;
            x.idx   = 4'd0;
            x.entry = mk(99);
            exp_q.push_back(x);
        end
        step();
        tail_m++;
        disp_valid = 1'b0;
        chk("t4_count_refill", count, 16);
        chk("t4_full_refill", full, 1'b1);

        // 5: flush half-full ROB with alloc + wb in flight
        do_flush();
        for (int i = 0; i < 8; i++) alloc(40 + i);
        wb(0);
        chk("t5_cvalid_pre", commit_valid, 1'b1);
        flush        = 1'b1;
        disp_valid   = 1'b1;
        disp_entry   = mk(77);
        wb_valid     = 1'b1;
        wb_idx       = 4'd3;
        commit_ready = 1'b1;
        chk("t5_cvalid_flush", commit_valid, 1'b1);
        step();
        flush        = 1'b0;
        disp_valid   = 1'b0;
        wb_valid     = 1'b0;
        commit_ready = 1'b0;
        exp_q.delete();
        tail_m = 0;
        chk("t5_count", count, 0);
        chk("t5_empty", empty, 1'b1);
        chk("t5_didx", disp_idx, 0);
        chk("t5_cvalid", commit_valid, 1'b0);
        wb(0);
        chk("t5_stale_count", count, 0);
        chk("t5_stale_empty", empty, 1'b1);
        alloc(50);
        chk("t5_new_not_done", commit_valid, 1'b0);

        // 6: asynchronous reset between edges
        alloc(51);
        alloc(52);
        wb(0);
        chk("t6_cvalid_pre", commit_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("arst");
        exp_q.delete();
        tail_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // post-reset round trip
        alloc(60);
        commit_ready = 1'b1;
        wb(0);
        chk("t6_cidx", commit_idx, 0);
        step();
        commit_ready = 1'b0;
        chk("t6_empty", empty, 1'b1);
        chk("q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
